card_dealer: RTL and testbench

Deck source for the blackjack datapath. Holds one 52-card deck and deals a random undealt card on request. Presents each card's blackjack value on a stable bus, then gives a clean registered one-cycle strobe. That strobe and value bus drive a hand controller's add-card strobe and new-card input directly. Shuffling returns all 52 cards to the deck.

---
 rtl/card_dealer_if.sv | 21 ++
 rtl/card_dealer.sv | 112 +++++++++++
 tb/tb_card_dealer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Request/card bus between the card dealer and its consumer (hand controller or bench).
interface card_dealer_if;
  logic       i_deal_req;
  logic       i_shuffle;
  logic       o_ready;
  logic [4:0] o_card;
  logic [5:0] o_card_index;
  logic       o_card_valid;
  logic [5:0] o_cards_left;
  logic       o_empty;

  modport master (
    output i_deal_req, i_shuffle,
    input  o_ready, o_card, o_card_index, o_card_valid, o_cards_left, o_empty
  );

  modport slave (
    input  i_deal_req, i_shuffle,
    output o_ready, o_card, o_card_index, o_card_valid, o_cards_left, o_empty
  );
endinterface

// File: rtl/card_dealer.sv
// 52-card deck: deals a random undealt card per request, then strobes its blackjack value.
// Optional CARD_DEALER_STACKED_DECK_EN deals cards in index order instead of LFSR order.
module card_dealer (
  input  logic         i_clk,
  input  logic         i_reset,
  card_dealer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_PRESENT,
    S_PULSE,
    S_EMPTY
  } state_t;

  state_t      state_q, state_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  probe_q, probe_d;
  logic [5:0]  left_q, left_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [4:0]  card_q, card_d;
  logic [5:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [5:0]  cand;

  function automatic logic [4:0] bj_value(input logic [5:0] idx);
    logic [5:0] rank;
    rank = idx % 6'd13;
    bj_value = (rank >= 6'd9) ? 5'd10 : rank[4:0] + 5'd1;
  endfunction

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

`ifdef CARD_DEALER_STACKED_DECK_EN
  assign cand = 6'd52 - left_q;
`else
  assign cand = (lfsr_q[5:0] >= 6'd52) ? lfsr_q[5:0] - 6'd52 : lfsr_q[5:0];
`endif

  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    probe_d = probe_q;
    left_d  = left_q;
    card_d  = card_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_deal_req && left_q != 6'd0) begin
          probe_d = cand;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (!used_q[probe_q]) begin
          used_d[probe_q] = 1'b1;
          left_d  = left_q - 6'd1;
          card_d  = bj_value(probe_q);
          idx_d   = probe_q;
          state_d = S_PRESENT;
        end else begin
          probe_d = (probe_q == 6'd51) ? 6'd0 : probe_q + 6'd1;
        end
      end
      S_PRESENT: state_d = S_PULSE;
      S_PULSE:   state_d = (left_q == 6'd0) ? S_EMPTY : S_IDLE;
      S_EMPTY:   state_d = S_EMPTY;
      default:   state_d = S_IDLE;
    endcase
    // Shuffle aborts any in-flight search without touching the presented card.
    if (bus.i_shuffle) begin
      used_d  = '0;
      left_d  = 6'd52;
      card_d  = card_q;
      idx_d   = idx_q;
      state_d = S_IDLE;
    end
    valid_d = (state_d == S_PULSE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      used_q  <= '0;
      probe_q <= '0;
      left_q  <= 6'd52;
      lfsr_q  <= 8'hA5;
      card_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      probe_q <= probe_d;
      left_q  <= left_d;
      lfsr_q  <= lfsr_d;
      card_q  <= card_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready      = (state_q == S_IDLE) && (left_q != 6'd0);
  assign bus.o_card       = card_q;
  assign bus.o_card_index = idx_q;
  assign bus.o_card_valid = valid_q;
  assign bus.o_cards_left = left_q;
  assign bus.o_empty      = (left_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: cycle vector table plus randomized full-deck deals.
module tb_card_dealer;

  logic clk;
  logic rst;
  card_dealer_if bus ();

  card_dealer dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  typedef struct {
    bit req;
    bit sh;
    bit ready;
    bit valid;
    int left;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_value(input int idx);
    int r;
    r = idx % 13;
    return (r >= 9) ? 10 : r + 1;
  endfunction

  task automatic do_reset();
    bus.i_deal_req = 1'b0;
    bus.i_shuffle  = 1'b0;
    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Deal one card; lat counts the accept cycle through the strobe cycle.
  task automatic deal(output int idx, output int val, output int lat, output bit timeout);
    int n;
    int prev_card;
    timeout = 1'b0;
    idx = -1; val = -1; lat = 0;
    prev_card = -1;
    n = 0;
    while (!bus.o_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    bus.i_deal_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.o_ready && n < 100);
    bus.i_deal_req = 1'b0;
    if (bus.o_ready) begin
      timeout = 1'b1;
      return;
    end
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (bus.o_card_valid) break;
      prev_card = int'(bus.o_card);
    end
    if (!bus.o_card_valid) begin
      timeout = 1'b1;
      return;
    end
    lat = n + 1;
    idx = int'(bus.o_card_index);
    val = int'(bus.o_card);
    chk("card_stable_before_strobe", val, prev_card);
  endtask

  initial begin
    bit seen[52];
    int exp_left;
    int idx, val, lat, nseen, strobes;
    bit to;

    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.i_deal_req = 1'b0;
    bus.i_shuffle  = 1'b0;

    // ---------------- cycle-level vector table ----------------
    tbl[0]  = '{req:0, sh:0, ready:1, valid:0, left:52};
    tbl[1]  = '{req:1, sh:0, ready:0, valid:0, left:52};
    tbl[2]  = '{req:0, sh:0, ready:0, valid:0, left:51};
    tbl[3]  = '{req:0, sh:0, ready:0, valid:1, left:51};
    tbl[4]  = '{req:0, sh:0, ready:1, valid:0, left:51};
    tbl[5]  = '{req:1, sh:0, ready:0, valid:0, left:51};
    tbl[6]  = '{req:0, sh:1, ready:1, valid:0, left:52};
    tbl[7]  = '{req:1, sh:1, ready:1, valid:0, left:52};
    tbl[8]  = '{req:0, sh:0, ready:1, valid:0, left:52};
    tbl[9]  = '{req:1, sh:0, ready:0, valid:0, left:52};
    tbl[10] = '{req:0, sh:0, ready:0, valid:0, left:51};
    tbl[11] = '{req:0, sh:0, ready:0, valid:1, left:51};
    tbl[12] = '{req:0, sh:0, ready:1, valid:0, left:51};

    do_reset();
    chk("reset_ready", int'(bus.o_ready), 1);
    chk("reset_card", int'(bus.o_card), 0);
    chk("reset_index", int'(bus.o_card_index), 0);
    chk("reset_valid", int'(bus.o_card_valid), 0);
    chk("reset_left", int'(bus.o_cards_left), 52);
    chk("reset_empty", int'(bus.o_empty), 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.i_deal_req = tbl[i].req;
      bus.i_shuffle  = tbl[i].sh;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ready", i), int'(bus.o_ready), int'(tbl[i].ready));
      chk($sformatf("vec%0d_valid", i), int'(bus.o_card_valid), int'(tbl[i].valid));
      chk($sformatf("vec%0d_left", i), int'(bus.o_cards_left), tbl[i].left);
      if (tbl[i].valid)
        chk($sformatf("vec%0d_value", i), int'(bus.o_card),
            exp_value(int'(bus.o_card_index)));
    end
    @(negedge clk);
    bus.i_deal_req = 1'b0;
    bus.i_shuffle  = 1'b0;

    // ---------------- full deck, random gaps ----------------
    do_reset();
    foreach (seen[k]) seen[k] = 1'b0;
    exp_left = 52;
    for (int n = 0; n < 52; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      deal(idx, val, lat, to);
      if (to) begin
        chk($sformatf("deal%0d_timeout", n), 1, 0);
        continue;
      end
      exp_left--;
      chk($sformatf("deal%0d_latency_range", n), int'(lat >= 3 && lat <= 54), 1);
      if (n == 0) chk("deal0_latency_first_hit", lat, 3);
`ifdef CARD_DEALER_STACKED_DECK_EN
      chk($sformatf("deal%0d_stacked_index", n), idx, n);
      chk($sformatf("deal%0d_stacked_latency", n), lat, 3);
`endif
      if (idx >= 0 && idx < 52) begin
        chk($sformatf("deal%0d_distinct", n), int'(seen[idx]), 0);
        seen[idx] = 1'b1;
      end else begin
        chk($sformatf("deal%0d_index_range", n), idx, 0);
      end
      chk($sformatf("deal%0d_value", n), val, exp_value(idx));
      chk($sformatf("deal%0d_left", n), int'(bus.o_cards_left), exp_left);
      chk($sformatf("deal%0d_empty", n), int'(bus.o_empty), int'(exp_left == 0));
      @(posedge clk); #1;
      chk($sformatf("deal%0d_strobe_one_cycle", n), int'(bus.o_card_valid), 0);
    end
    nseen = 0;
    foreach (seen[k]) nseen += int'(seen[k]);
    chk("deck_coverage", nseen, 52);
    chk("after52_empty", int'(bus.o_empty), 1);
    chk("after52_ready", int'(bus.o_ready), 0);

    // A request against an empty deck must never strobe.
    @(negedge clk);
    bus.i_deal_req = 1'b1;
    strobes = 0;
    repeat (60) begin
      @(posedge clk); #1;
      strobes += int'(bus.o_card_valid);
    end
    bus.i_deal_req = 1'b0;
    chk("empty_request_strobes", strobes, 0);

    @(negedge clk);
    bus.i_shuffle = 1'b1;
    @(negedge clk);
    bus.i_shuffle = 1'b0;
    chk("shuffle_left", int'(bus.o_cards_left), 52);
    chk("shuffle_ready", int'(bus.o_ready), 1);
    chk("shuffle_empty", int'(bus.o_empty), 0);
    deal(idx, val, lat, to);
    chk("post_shuffle_timeout", int'(to), 0);
    chk("post_shuffle_latency", lat, 3);
    chk("post_shuffle_value", val, exp_value(idx));
`ifdef CARD_DEALER_STACKED_DECK_EN
    chk("post_shuffle_index", idx, 0);
    chk("post_shuffle_value1", val, 1);
`endif

    // ---------------- asynchronous reset during PRESENT ----------------
    do_reset();
    @(negedge clk);
    bus.i_deal_req = 1'b1;
    @(posedge clk); #1;
    bus.i_deal_req = 1'b0;
    @(posedge clk); #1;
    chk("present_card_loaded", int'(bus.o_card != 5'd0), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_card", int'(bus.o_card), 0);
    chk("async_reset_valid", int'(bus.o_card_valid), 0);
    chk("async_reset_left", int'(bus.o_cards_left), 52);
    strobes = 0;
    repeat (3) begin
      @(posedge clk); #1;
      strobes += int'(bus.o_card_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      strobes += int'(bus.o_card_valid);
    end
    chk("async_reset_no_strobe", strobes, 0);
    chk("async_reset_ready", int'(bus.o_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
